// File: rtl/isa_camac_bridge.sv
// ISA I/O slave that maps 8-bit port accesses onto 16-bit CAMAC dataway cycles.
// Latency: CAMAC cycle starts one clock after the registered strobe falling edge; wait states until ack or timeout.
// Backpressure: isa_chrdy is held low from SETUP through HOLD; strobe edges seen outside IDLE are ignored.
module isa_camac_bridge #(
    parameter logic [9:0]  BASE_ADDR      = 10'h106,
    parameter int          NUM_CH         = 4,
    parameter logic [11:0] CB_ADDR_BASE   = 12'h000,
    parameter int          STROBE_CYCLES  = 2,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        isa_clk,
    input  logic        isa_reset,
    input  logic        isa_ior,
    input  logic        isa_iow,
    input  logic        isa_ale,
    input  logic        isa_aen,
    input  logic [9:0]  isa_addr,
    input  logic [7:0]  isa_data_in,
    output logic [7:0]  isa_data_out,
    output logic        isa_data_oe,
    output logic        isa_chrdy,
    output logic        isa_irq,
    output logic [11:0] cb_addr,
    output logic        cb_cx1,
    output logic        cb_b_b1,
    input  logic [15:0] cb_data_in,
    output logic [15:0] cb_data_out,
    input  logic        cb_zk4,
    input  logic        cb_prr
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_HOLD, S_DONE} state_t;

    localparam logic [9:0]  STAT_OFF = 10'(2 * NUM_CH);
    localparam logic [15:0] STB_LAST = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [9:0]  addr_q;
    logic        ior_q, ior_p_q, iow_q, iow_p_q, aen_q;
    logic        prr_q, prr_p_q;
    logic [7:0]  stage_q, hi_q, dout_q;
    logic [11:0] cba_q;
    logic [15:0] cbd_q;
    logic        wr_q, rd_act_q, rd_pass_q, tmo_err_q, prr_pend_q;
    logic [15:0] stb_cnt_q, tmo_cnt_q;

    // Address decode and event qualification
    logic [9:0] off;
    logic [2:0] ch;
    logic       hit, is_stat, is_hi, idle;
    logic       rd_fall, wr_fall, go_rd, go_wr, wr_lo, rd_hi, rd_stat;
    logic       ack, tmo, released;

    assign off      = addr_q - BASE_ADDR;
    assign ch       = off[3:1];
    assign hit      = !aen_q && (addr_q >= BASE_ADDR) && (off <= STAT_OFF);
    assign is_stat  = (off == STAT_OFF);
    assign is_hi    = off[0];
    assign idle     = (state_q == S_IDLE);
    // A falling edge on one strobe only counts while the other strobe is inactive.
    assign rd_fall  = ior_p_q & ~ior_q & iow_q;
    assign wr_fall  = iow_p_q & ~iow_q & ior_q;
    assign go_rd    = idle & rd_fall & hit & ~is_stat & ~is_hi;
    assign go_wr    = idle & wr_fall & hit & ~is_stat & is_hi;
    assign wr_lo    = idle & wr_fall & hit & ~is_stat & ~is_hi;
    assign rd_hi    = idle & rd_fall & hit & ~is_stat & is_hi;
    assign rd_stat  = idle & rd_fall & hit & is_stat;
    assign ack      = (state_q == S_WAIT) & ~cb_zk4;
    assign tmo      = (state_q == S_WAIT) & cb_zk4 & (tmo_cnt_q == TMO_LAST);
    assign released = ior_q & iow_q;

    // FSM state register
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (go_rd || go_wr) state_d = S_SETUP;
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: if (stb_cnt_q == STB_LAST) state_d = S_WAIT;
            S_WAIT:   if (ack || tmo) state_d = S_HOLD;
            S_HOLD:   state_d = S_DONE;
            S_DONE:   if (released) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: strobe, write drive and wait-state control
    always_comb begin
        cb_cx1    = (state_q == S_STROBE);
        cb_b_b1   = wr_q & (state_q inside {S_SETUP, S_STROBE, S_WAIT, S_HOLD});
        isa_chrdy = !(state_q inside {S_SETUP, S_STROBE, S_WAIT, S_HOLD});
    end

    // Strobe length and acknowledge timeout counters (timeout counts from STROBE entry)
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            stb_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            stb_cnt_q <= (state_q == S_STROBE) ? stb_cnt_q + 16'd1 : '0;
            tmo_cnt_q <= (state_q inside {S_STROBE, S_WAIT}) ? tmo_cnt_q + 16'd1 : '0;
        end
    end

    // Bus input sampling: address latch, strobe edge pipeline, service request edge
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            addr_q  <= '0;
            ior_q   <= 1'b1;
            ior_p_q <= 1'b1;
            iow_q   <= 1'b1;
            iow_p_q <= 1'b1;
            aen_q   <= 1'b0;
            prr_q   <= 1'b1;
            prr_p_q <= 1'b1;
        end else begin
            if (isa_ale) addr_q <= isa_addr;
            ior_q   <= isa_ior;
            ior_p_q <= ior_q;
            iow_q   <= isa_iow;
            iow_p_q <= iow_q;
            aen_q   <= isa_aen;
            prr_q   <= cb_prr;
            prr_p_q <= prr_q;
        end
    end

    // Transfer datapath: staging byte, CAMAC address/data, read latches and status flags
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            stage_q    <= '0;
            hi_q       <= '0;
            dout_q     <= '0;
            cba_q      <= '0;
            cbd_q      <= '0;
            wr_q       <= 1'b0;
            rd_act_q   <= 1'b0;
            rd_pass_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            prr_pend_q <= 1'b0;
        end else begin
            if (wr_lo) stage_q <= isa_data_in;
            if (go_rd || go_wr) begin
                cba_q <= CB_ADDR_BASE + 12'(ch);
                wr_q  <= go_wr;
            end
            if (go_wr) cbd_q <= {isa_data_in, stage_q};
            if (ack && !wr_q) begin
                dout_q <= cb_data_in[7:0];
                hi_q   <= cb_data_in[15:8];
            end else if (tmo && !wr_q) begin
                dout_q <= 8'hFF;
                hi_q   <= 8'hFF;
            end else if (rd_hi) begin
                dout_q <= hi_q;
            end else if (rd_stat) begin
                dout_q <= {5'b0, prr_pend_q, tmo_err_q, !idle};
            end
            // Decoded read tracking drives the data bus enable until the strobe releases.
            if (go_rd || rd_hi || rd_stat) begin
                rd_act_q  <= 1'b1;
                rd_pass_q <= rd_hi | rd_stat;
            end else if (ior_q) begin
                rd_act_q  <= 1'b0;
                rd_pass_q <= 1'b0;
            end
            if (tmo)          tmo_err_q <= 1'b1;
            else if (rd_stat) tmo_err_q <= 1'b0;
            if (prr_p_q && !prr_q) prr_pend_q <= 1'b1;
            else if (rd_stat)      prr_pend_q <= 1'b0;
        end
    end

    assign isa_data_oe  = rd_act_q & ~ior_q & (rd_pass_q | (state_q == S_DONE));
    assign isa_data_out = dout_q;
    assign isa_irq      = prr_pend_q;
    assign cb_addr      = cba_q;
    assign cb_data_out  = cbd_q;

endmodule

// File: tb/tb_isa_camac_bridge.sv
// Bench for isa_camac_bridge: ISA bus master tasks, a CAMAC responder and a read-data scoreboard.
module tb_isa_camac_bridge;

    logic        isa_clk = 1'b0;
    logic        isa_reset = 1'b0;
    logic        isa_ior = 1'b1, isa_iow = 1'b1, isa_ale = 1'b0, isa_aen = 1'b0;
    logic [9:0]  isa_addr = '0;
    logic [7:0]  isa_data_in = '0;
    logic [7:0]  isa_data_out;
    logic        isa_data_oe, isa_chrdy, isa_irq;
    logic [11:0] cb_addr;
    logic        cb_cx1, cb_b_b1;
    logic [15:0] cb_data_in = '0;
    logic [15:0] cb_data_out;
    logic        cb_zk4 = 1'b1, cb_prr = 1'b1;

    isa_camac_bridge dut (
        .isa_clk(isa_clk), .isa_reset(isa_reset), .isa_ior(isa_ior), .isa_iow(isa_iow),
        .isa_ale(isa_ale), .isa_aen(isa_aen), .isa_addr(isa_addr),
        .isa_data_in(isa_data_in), .isa_data_out(isa_data_out), .isa_data_oe(isa_data_oe),
        .isa_chrdy(isa_chrdy), .isa_irq(isa_irq), .cb_addr(cb_addr), .cb_cx1(cb_cx1),
        .cb_b_b1(cb_b_b1), .cb_data_in(cb_data_in), .cb_data_out(cb_data_out),
        .cb_zk4(cb_zk4), .cb_prr(cb_prr)
    );

    always #5 isa_clk = ~isa_clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CAMAC responder and bus monitors, all sampled on the falling clock edge.
    logic        ack_en = 1'b1;
    logic        rx_prev = 1'b0;
    int          rx_k = -1;
    int          pulses = 0, cx1_len = 0, bb1_cnt = 0, oe_cnt = 0;
    logic [11:0] cap_addr = '0;
    logic [15:0] cap_dout = '0;
    logic        cap_bb1 = 1'b0;

    initial begin
        forever begin
            @(negedge isa_clk);
            if (cb_cx1 && !rx_prev) begin
                pulses++;
                cx1_len  = 0;
                cap_addr = cb_addr;
                cap_dout = cb_data_out;
                cap_bb1  = cb_b_b1;
                rx_k     = 0;
            end
            if (cb_cx1) cx1_len++;
            if (cb_b_b1) bb1_cnt++;
            if (isa_data_oe) oe_cnt++;
            // Acknowledge is presented three clocks after the strobe rises.
            if (rx_k >= 0) begin
                if (ack_en && rx_k == 2) cb_zk4 = 1'b0;
                if (rx_k == 4) begin
                    cb_zk4 = 1'b1;
                    rx_k = -1;
                end else rx_k++;
            end
            rx_prev = cb_cx1;
        end
    end

    task automatic isa_rd(input logic [9:0] a, input logic aen, input logic cyc,
                          output logic [7:0] d, output logic oe, output int lowcnt);
        int n;
        @(negedge isa_clk); isa_addr = a; isa_aen = aen; isa_ale = 1'b1;
        @(negedge isa_clk); isa_ale = 1'b0;
        @(negedge isa_clk); isa_ior = 1'b0;
        lowcnt = 0;
        if (cyc) begin
            n = 0;
            while (isa_chrdy && n < 8) begin @(negedge isa_clk); n++; end
            chk("chrdy_drop", isa_chrdy, 1'b0);
            n = 0;
            while (!isa_chrdy && n < 200) begin @(negedge isa_clk); lowcnt++; n++; end
            chk("chrdy_rise", isa_chrdy, 1'b1);
        end else begin
            repeat (4) @(negedge isa_clk);
        end
        @(negedge isa_clk);
        d  = isa_data_out;
        oe = isa_data_oe;
        isa_ior = 1'b1;
        repeat (3) @(negedge isa_clk);
    endtask

    task automatic isa_wr(input logic [9:0] a, input logic [7:0] v, input logic cyc, output int lowcnt);
        int n;
        @(negedge isa_clk); isa_addr = a; isa_aen = 1'b0; isa_ale = 1'b1;
        @(negedge isa_clk); isa_ale = 1'b0; isa_data_in = v;
        @(negedge isa_clk); isa_iow = 1'b0;
        lowcnt = 0;
        if (cyc) begin
            n = 0;
            while (isa_chrdy && n < 8) begin @(negedge isa_clk); n++; end
            chk("wr_chrdy_drop", isa_chrdy, 1'b0);
            n = 0;
            while (!isa_chrdy && n < 200) begin @(negedge isa_clk); lowcnt++; n++; end
            chk("wr_chrdy_rise", isa_chrdy, 1'b1);
        end else begin
            repeat (4) @(negedge isa_clk);
        end
        @(negedge isa_clk);
        isa_iow = 1'b1;
        repeat (3) @(negedge isa_clk);
    endtask

    // Read scoreboard: expected byte queued at stimulus, popped when the DUT drives the bus.
    logic [7:0] exp_q[$];

    task automatic rd_chk(input string tag, input logic [9:0] a, input logic cyc,
                          input logic [7:0] e, input int elow);
        logic [7:0] d, want;
        logic       oe;
        int         low;
        exp_q.push_back(e);
        isa_rd(a, 1'b0, cyc, d, oe, low);
        want = exp_q.pop_front();
        chk({tag, "_oe"}, oe, 1'b1);
        if (oe) chk({tag, "_dat"}, d, want);
        if (elow >= 0) chk({tag, "_wait"}, low, elow);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         p0, b0, o0, low;
        logic [7:0] d;
        logic       oe;

        // Reset state
        repeat (3) @(negedge isa_clk);
        chk("rst_chrdy", isa_chrdy, 1'b1);
        chk("rst_oe", isa_data_oe, 1'b0);
        chk("rst_dout", isa_data_out, 8'h00);
        chk("rst_cb", {cb_cx1, cb_b_b1, cb_addr, cb_data_out}, 30'h0);
        chk("rst_irq", isa_irq, 1'b0);
        isa_reset = 1'b1;
        repeat (3) @(negedge isa_clk);
        rd_chk("stat0", 10'h10E, 1'b0, 8'h00, -1);

        // Channel 0 read, then high byte from the latch with no CAMAC cycle
        cb_data_in = 16'hA55A;
        p0 = pulses;
        rd_chk("r106", 10'h106, 1'b1, 8'h5A, 5);
        chk("r106_pulses", pulses - p0, 1);
        chk("r106_cx1len", cx1_len, 2);
        chk("r106_addr", cap_addr, 12'h000);
        chk("r106_bb1", cap_bb1, 1'b0);
        p0 = pulses;
        rd_chk("r107", 10'h107, 1'b0, 8'hA5, -1);
        chk("r107_nocyc", pulses - p0, 0);

        // Channel 1 write: low byte stages only, high byte launches the cycle
        p0 = pulses;
        isa_wr(10'h108, 8'h34, 1'b0, low);
        chk("w108_nocyc", pulses - p0, 0);
        b0 = bb1_cnt;
        isa_wr(10'h109, 8'h12, 1'b1, low);
        chk("w109_pulses", pulses - p0, 1);
        chk("w109_cx1len", cx1_len, 2);
        chk("w109_addr", cap_addr, 12'h001);
        chk("w109_data", cap_dout, 16'h1234);
        chk("w109_bb1", cap_bb1, 1'b1);
        chk("w109_bb1len", bb1_cnt - b0, 5);
        chk("w109_wait", low, 5);

        // Last channel read
        cb_data_in = 16'hBEEF;
        rd_chk("r10c", 10'h10C, 1'b1, 8'hEF, 5);
        chk("r10c_addr", cap_addr, 12'h003);
        rd_chk("r10d", 10'h10D, 1'b0, 8'hBE, -1);

        // Acknowledge timeout: SETUP + 64 clocks + HOLD of wait states
        ack_en = 1'b0;
        rd_chk("tmo", 10'h106, 1'b1, 8'hFF, 66);
        ack_en = 1'b1;
        rd_chk("tmo_stat1", 10'h10E, 1'b0, 8'h02, -1);
        rd_chk("tmo_stat2", 10'h10E, 1'b0, 8'h00, -1);

        // Unmapped addresses, DMA cycle and the first address past status stay passive
        p0 = pulses;
        o0 = oe_cnt;
        for (int i = 0; i < 3; i++) begin
            isa_rd(10'h200, 1'b0, 1'b0, d, oe, low);
            chk("r200_oe", oe, 1'b0);
        end
        isa_rd(10'h106, 1'b1, 1'b0, d, oe, low);
        chk("aen_oe", oe, 1'b0);
        isa_rd(10'h10F, 1'b0, 1'b0, d, oe, low);
        chk("r10f_oe", oe, 1'b0);
        chk("passive_oecnt", oe_cnt - o0, 0);
        chk("passive_pulses", pulses - p0, 0);

        // Service request
        chk("irq_idle", isa_irq, 1'b0);
        @(negedge isa_clk); cb_prr = 1'b0;
        repeat (2) @(negedge isa_clk); cb_prr = 1'b1;
        repeat (3) @(negedge isa_clk);
        chk("irq_set", isa_irq, 1'b1);
        rd_chk("prr_stat", 10'h10E, 1'b0, 8'h04, -1);
        chk("irq_clr", isa_irq, 1'b0);

        // Reset during STROBE aborts the cycle
        ack_en = 1'b0;
        @(negedge isa_clk); isa_addr = 10'h106; isa_aen = 1'b0; isa_ale = 1'b1;
        @(negedge isa_clk); isa_ale = 1'b0;
        @(negedge isa_clk); isa_ior = 1'b0;
        for (int n = 0; n < 20 && !cb_cx1; n++) @(negedge isa_clk);
        chk("abort_cx1_seen", cb_cx1, 1'b1);
        isa_reset = 1'b0;
        #1;
        chk("abort_cx1", cb_cx1, 1'b0);
        chk("abort_chrdy", isa_chrdy, 1'b1);
        chk("abort_oe", isa_data_oe, 1'b0);
        @(negedge isa_clk); isa_ior = 1'b1;
        repeat (2) @(negedge isa_clk); isa_reset = 1'b1;
        p0 = pulses;
        repeat (6) @(negedge isa_clk);
        chk("post_abort_quiet", {cb_cx1, isa_chrdy, isa_data_oe}, 3'b010);
        chk("post_abort_pulses", pulses - p0, 0);
        ack_en = 1'b1;
        rd_chk("post_r107", 10'h107, 1'b0, 8'h00, -1);
        cb_data_in = 16'h7788;
        rd_chk("post_r106", 10'h106, 1'b1, 8'h88, 5);
        chk("post_pulses", pulses - p0, 1);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
